// File: rtl/mem_stage_pkg.sv
// Shared CPU parameters for the memory stage: instruction-type bit indices,
// reset values, bypass-select encoding, data-memory geometry and hazard-count helper.
package mem_stage_pkg;

  localparam int unsigned IT_W = 60;

  localparam int unsigned IT_SLL = 0;
  localparam int unsigned IT_LB  = 16;
  localparam int unsigned IT_LBU = 17;
  localparam int unsigned IT_LH  = 18;
  localparam int unsigned IT_LHU = 19;
  localparam int unsigned IT_LW  = 20;
  localparam int unsigned IT_SB  = 26;
  localparam int unsigned IT_SH  = 27;
  localparam int unsigned IT_SW  = 28;

  localparam logic [31:0]     RESET_PC     = 32'h0000_3000;
  localparam logic [IT_W-1:0] BUBBLE_INSTR = 60'd1 << IT_SLL;
  localparam logic [4:0]      BUBBLE_RWA   = 5'd0;

  typedef enum logic {
    BYP_DM_DATA = 1'b0,
    BYP_WB      = 1'b1
  } byp_sel_e;

  localparam int unsigned DM_DEPTH = 1024;
  localparam int unsigned DM_AW    = 10;

  localparam logic [2:0] TUSE_NONE = 3'b111;

  // Saturating decrement of a hazard count; Tuse "no use" is sticky.
  function automatic logic [2:0] dec_timing(input logic [2:0] t, input logic hold_none);
    logic [2:0] r;
    if (hold_none && (t == TUSE_NONE)) r = t;
    else if (t != 3'd0) r = t - 3'd1;
    else r = 3'd0;
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_dm_subword.sv
// Byte-enable generation for sb/sh/sw and sign/zero extension for lb/lbu/lh/lhu.
// Only instantiated when MEM_SUBWORD_EN is defined.
module dm_subword
  import mem_stage_pkg::*;
(
  input  logic [IT_W-1:0] instr_type,
  input  logic [1:0]      byte_off,
  input  logic [31:0]     store_data,
  input  logic [31:0]     rd_word,
  output logic            wr_en,
  output logic [31:0]     wr_word,
  output logic [31:0]     load_data
);

  logic [3:0]  be_s;
  logic [31:0] lane_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        unused_s;

  assign unused_s = ^instr_type;

  // Byte enables and lane-replicated store data.
  always_comb begin
    be_s   = 4'b0000;
    lane_s = store_data;
    if (instr_type[IT_SW]) begin
      be_s = 4'b1111;
    end else if (instr_type[IT_SH]) begin
      be_s   = byte_off[1] ? 4'b1100 : 4'b0011;
      lane_s = {2{store_data[15:0]}};
    end else if (instr_type[IT_SB]) begin
      be_s   = 4'b0001 << byte_off;
      lane_s = {4{store_data[7:0]}};
    end else begin
      be_s = 4'b0000;
    end
  end

  // Unselected lanes keep the current word so the array always writes whole words.
  assign wr_word = {be_s[3] ? lane_s[31:24] : rd_word[31:24],
                    be_s[2] ? lane_s[23:16] : rd_word[23:16],
                    be_s[1] ? lane_s[15:8]  : rd_word[15:8],
                    be_s[0] ? lane_s[7:0]   : rd_word[7:0]};
  assign wr_en   = |be_s;

  // Little-endian lane extraction and extension.
  always_comb begin
    byte_s = rd_word[{byte_off, 3'b000} +: 8];
    half_s = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    if (instr_type[IT_LB])       load_data = {{24{byte_s[7]}}, byte_s};
    else if (instr_type[IT_LBU]) load_data = {24'd0, byte_s};
    else if (instr_type[IT_LH])  load_data = {{16{half_s[15]}}, half_s};
    else if (instr_type[IT_LHU]) load_data = {16'd0, half_s};
    else                         load_data = rd_word;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: 1024-word data memory plus the Mem/WB register.
// Sub-word loads/stores are enabled by defining MEM_SUBWORD_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     PC_in,
  input  logic [4:0]      RAddr0_in,
  input  logic [4:0]      RAddr1_in,
  input  logic [4:0]      RegWriteAddr_in,
  input  logic [IT_W-1:0] InstrType_in,
  input  logic [31:0]     ALUOut_in,
  input  logic [31:0]     DMWriteData_in,
  input  logic [2:0]      Tuse0_in,
  input  logic [2:0]      Tuse1_in,
  input  logic [2:0]      Tnew_in,
  input  logic [31:0]     bypass_WB,
  input  logic            DMWriteDataBypassCtrl,
  output logic [31:0]     PC_out,
  output logic [31:0]     ALUOut_out,
  output logic [31:0]     DMReadData_out,
  output logic [4:0]      RegWriteAddr_out,
  output logic [IT_W-1:0] InstrType_out,
  output logic [2:0]      Tnew_out,
  output logic [4:0]      RegWriteAddr_Mem,
  output logic [2:0]      Tnew_Mem,
  output logic [2:0]      Tuse0_Mem,
  output logic [2:0]      Tuse1_Mem,
  output logic [4:0]      RAddr1_Mem
);

  logic [31:0]      dm_r [DM_DEPTH];
  logic [DM_AW-1:0] word_idx_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      store_data_s;
  logic [31:0]      wr_word_s;
  logic [31:0]      load_data_s;
  logic             wr_en_s;
  logic             unused_s;

  assign unused_s   = ^RAddr0_in;
  assign word_idx_s = ALUOut_in[11:2];
  assign rd_word_s  = dm_r[word_idx_s];

  assign RegWriteAddr_Mem = RegWriteAddr_in;
  assign RAddr1_Mem       = RAddr1_in;
  assign Tnew_Mem         = dec_timing(Tnew_in, 1'b0);
  assign Tuse0_Mem        = dec_timing(Tuse0_in, 1'b1);
  assign Tuse1_Mem        = dec_timing(Tuse1_in, 1'b1);

  // Store-data bypass select.
  always_comb begin
    if (DMWriteDataBypassCtrl == BYP_WB) store_data_s = bypass_WB;
    else                                 store_data_s = DMWriteData_in;
  end

`ifdef MEM_SUBWORD_EN
  dm_subword u_dm_subword (
    .instr_type (InstrType_in),
    .byte_off   (ALUOut_in[1:0]),
    .store_data (store_data_s),
    .rd_word    (rd_word_s),
    .wr_en      (wr_en_s),
    .wr_word    (wr_word_s),
    .load_data  (load_data_s)
  );
`else
  assign wr_en_s     = InstrType_in[IT_SW];
  assign wr_word_s   = store_data_s;
  assign load_data_s = rd_word_s;
`endif

  // Data array: whole-memory clear on reset, word write otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_DEPTH; i++) dm_r[i[DM_AW-1:0]] <= 32'd0;
    end else if (wr_en_s) begin
      dm_r[word_idx_s] <= wr_word_s;
    end
  end

  // Mem/WB pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_out           <= RESET_PC;
      InstrType_out    <= BUBBLE_INSTR;
      ALUOut_out       <= 32'd0;
      DMReadData_out   <= 32'd0;
      RegWriteAddr_out <= BUBBLE_RWA;
      Tnew_out         <= 3'd0;
    end else begin
      PC_out           <= PC_in;
      InstrType_out    <= InstrType_in;
      ALUOut_out       <= ALUOut_in;
      DMReadData_out   <= load_data_s;
      RegWriteAddr_out <= RegWriteAddr_in;
      Tnew_out         <= Tnew_Mem;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a byte-addressed behavioural memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic            clk;
  logic            reset;
  logic [31:0]     PC_in;
  logic [4:0]      RAddr0_in, RAddr1_in, RegWriteAddr_in;
  logic [IT_W-1:0] InstrType_in;
  logic [31:0]     ALUOut_in, DMWriteData_in, bypass_WB;
  logic [2:0]      Tuse0_in, Tuse1_in, Tnew_in;
  logic            DMWriteDataBypassCtrl;
  logic [31:0]     PC_out, ALUOut_out, DMReadData_out;
  logic [4:0]      RegWriteAddr_out, RegWriteAddr_Mem, RAddr1_Mem;
  logic [IT_W-1:0] InstrType_out;
  logic [2:0]      Tnew_out, Tnew_Mem, Tuse0_Mem, Tuse1_Mem;

  mem_stage dut (
    .clk(clk), .reset(reset), .PC_in(PC_in), .RAddr0_in(RAddr0_in), .RAddr1_in(RAddr1_in),
    .RegWriteAddr_in(RegWriteAddr_in), .InstrType_in(InstrType_in), .ALUOut_in(ALUOut_in),
    .DMWriteData_in(DMWriteData_in), .Tuse0_in(Tuse0_in), .Tuse1_in(Tuse1_in), .Tnew_in(Tnew_in),
    .bypass_WB(bypass_WB), .DMWriteDataBypassCtrl(DMWriteDataBypassCtrl),
    .PC_out(PC_out), .ALUOut_out(ALUOut_out), .DMReadData_out(DMReadData_out),
    .RegWriteAddr_out(RegWriteAddr_out), .InstrType_out(InstrType_out), .Tnew_out(Tnew_out),
    .RegWriteAddr_Mem(RegWriteAddr_Mem), .Tnew_Mem(Tnew_Mem), .Tuse0_Mem(Tuse0_Mem),
    .Tuse1_Mem(Tuse1_Mem), .RAddr1_Mem(RAddr1_Mem)
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Behavioural model state: 4 KiB byte memory and expected Mem/WB contents.
  logic [7:0]      mem_b [4096];
  logic [31:0]     e_pc, e_alu, e_rd;
  logic [IT_W-1:0] e_it;
  logic [4:0]      e_rwa;
  logic [2:0]      e_tnew;
  int unsigned     kinds [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_tnew(input logic [2:0] t);
    return (t > 3'd0) ? t - 3'd1 : 3'd0;
  endfunction

  function automatic logic [2:0] m_tuse(input logic [2:0] t);
    return (t == 3'd7) ? 3'd7 : m_tnew(t);
  endfunction

  function automatic logic [31:0] m_word(input logic [11:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {mem_b[b + 12'd3], mem_b[b + 12'd2], mem_b[b + 12'd1], mem_b[b]};
  endfunction

  // Model step at each rising edge, using the inputs the DUT samples.
  task automatic model_edge();
    logic [11:0] a;
    logic [31:0] sd, rd;
    logic [15:0] h;
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem_b[i] = 8'd0;
      e_pc = 32'h0000_3000; e_it = BUBBLE_INSTR; e_alu = 32'd0;
      e_rd = 32'd0; e_rwa = 5'd0; e_tnew = 3'd0;
    end else begin
      a  = ALUOut_in[11:0];
      sd = DMWriteDataBypassCtrl ? bypass_WB : DMWriteData_in;
      rd = m_word(a);
`ifdef MEM_SUBWORD_EN
      h = {mem_b[{a[11:1], 1'b1}], mem_b[{a[11:1], 1'b0}]};
      if (InstrType_in[IT_LB])  rd = {{24{mem_b[a][7]}}, mem_b[a]};
      if (InstrType_in[IT_LBU]) rd = {24'd0, mem_b[a]};
      if (InstrType_in[IT_LH])  rd = {{16{h[15]}}, h};
      if (InstrType_in[IT_LHU]) rd = {16'd0, h};
      if (InstrType_in[IT_SB])  mem_b[a] = sd[7:0];
      if (InstrType_in[IT_SH]) begin
        mem_b[{a[11:1], 1'b0}] = sd[7:0];
        mem_b[{a[11:1], 1'b1}] = sd[15:8];
      end
`else
      h = 16'd0;
`endif
      if (InstrType_in[IT_SW]) begin
        for (int k = 0; k < 4; k++) mem_b[{a[11:2], 2'(k)}] = sd[8*k +: 8];
      end
      e_pc = PC_in; e_it = InstrType_in; e_alu = ALUOut_in; e_rd = rd;
      e_rwa = RegWriteAddr_in; e_tnew = m_tnew(Tnew_in);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input int unsigned it, input logic [31:0] alu, input logic [31:0] wd,
                       input logic ctrl, input logic [31:0] byp);
    PC_in = $urandom(); RAddr0_in = 5'($urandom()); RAddr1_in = 5'($urandom());
    RegWriteAddr_in = 5'($urandom()); Tuse0_in = 3'($urandom()); Tuse1_in = 3'($urandom());
    Tnew_in = 3'($urandom());
    InstrType_in = 60'd0; InstrType_in[it] = 1'b1;
    ALUOut_in = alu; DMWriteData_in = wd; DMWriteDataBypassCtrl = ctrl; bypass_WB = byp;
  endtask

  // Compare process: every cycle, registered outputs vs model and combinational view vs rules.
  always @(negedge clk) begin
    if (chk_en) begin
      check("PC_out", PC_out, e_pc);
      check("InstrType_out", InstrType_out, e_it);
      check("ALUOut_out", ALUOut_out, e_alu);
      check("DMReadData_out", DMReadData_out, e_rd);
      check("RegWriteAddr_out", RegWriteAddr_out, e_rwa);
      check("Tnew_out", Tnew_out, e_tnew);
      check("RegWriteAddr_Mem", RegWriteAddr_Mem, RegWriteAddr_in);
      check("RAddr1_Mem", RAddr1_Mem, RAddr1_in);
      check("Tnew_Mem", Tnew_Mem, m_tnew(Tnew_in));
      check("Tuse0_Mem", Tuse0_Mem, m_tuse(Tuse0_in));
      check("Tuse1_Mem", Tuse1_Mem, m_tuse(Tuse1_in));
    end
  end

  initial begin
    kinds = '{IT_SLL, IT_LW, IT_SW, IT_LB, IT_LBU, IT_LH, IT_LHU, IT_SB, IT_SH, 45};
    reset = 1'b1;
    drive(IT_SLL, 32'd0, 32'd0, 1'b0, 32'd0);
    cycle();
    cycle();
    chk_en = 1'b1;
    check("reset_pc", PC_out, 64'h3000);
    check("reset_instr", InstrType_out, 64'd1);
    check("reset_rd", DMReadData_out, 64'd0);
    check("reset_tnew", Tnew_out, 64'd0);
    reset = 1'b0;

    drive(IT_SW, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    cycle();
    drive(IT_LW, 32'h10, 32'h0, 1'b0, 32'h0);
    cycle();
    check("lw_after_sw", DMReadData_out, 64'hDEADBEEF);

    drive(IT_SW, 32'h40, 32'h0, 1'b1, 32'h12345678);
    cycle();
    drive(IT_LW, 32'h40, 32'h0, 1'b0, 32'h0);
    cycle();
    check("sw_bypass", DMReadData_out, 64'h12345678);

    drive(IT_SLL, 32'h0, 32'h0, 1'b0, 32'h0);
    Tnew_in = 3'd2; Tuse0_in = 3'd0; Tuse1_in = 3'd7;
    #1;
    check("tnew_mem", Tnew_Mem, 64'd1);
    check("tuse0_mem", Tuse0_Mem, 64'd0);
    check("tuse1_mem", Tuse1_Mem, 64'd7);
    cycle();
    check("tnew_out", Tnew_out, 64'd1);

    drive(IT_SW, 32'h10, 32'h55, 1'b0, 32'h0);
    reset = 1'b1;
    cycle();
    check("pc_in_reset", PC_out, 64'h3000);
    reset = 1'b0;
    drive(IT_LW, 32'h10, 32'h0, 1'b0, 32'h0);
    cycle();
    check("lw_after_reset", DMReadData_out, 64'd0);

    drive(IT_SW, 32'h1000, 32'hCAFEF00D, 1'b0, 32'h0);
    cycle();
    drive(IT_LW, 32'h0, 32'h0, 1'b0, 32'h0);
    cycle();
    check("alias_1000", DMReadData_out, 64'hCAFEF00D);

`ifdef MEM_SUBWORD_EN
    drive(IT_SW, 32'h20, 32'h80FF7F01, 1'b0, 32'h0); cycle();
    drive(IT_LB, 32'h23, 32'h0, 1'b0, 32'h0);        cycle();
    check("lb_23", DMReadData_out, 64'hFFFFFF80);
    drive(IT_LBU, 32'h23, 32'h0, 1'b0, 32'h0);       cycle();
    check("lbu_23", DMReadData_out, 64'h80);
    drive(IT_LH, 32'h20, 32'h0, 1'b0, 32'h0);        cycle();
    check("lh_20", DMReadData_out, 64'h7F01);
    drive(IT_SB, 32'h21, 32'hAA, 1'b0, 32'h0);       cycle();
    drive(IT_LW, 32'h20, 32'h0, 1'b0, 32'h0);        cycle();
    check("sb_21", DMReadData_out, 64'h80FFAA01);
    drive(IT_LH, 32'h22, 32'h0, 1'b0, 32'h0);        cycle();
    check("lh_22", DMReadData_out, 64'hFFFF80FF);
`endif

    for (int n = 0; n < 400; n++) begin
      logic [31:0] alu;
      alu = $urandom();
      alu[11:6] = 6'd0;
      drive(kinds[$urandom_range(0, 9)], alu, $urandom(), 1'($urandom_range(0, 1)), $urandom());
      reset = ($urandom_range(0, 24) == 0);
      cycle();
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
